// File: rtl/equiv_sweep_ctrl.sv
// equiv_sweep_ctrl
//   Exhaustive equivalence sweeper. Walks every N_IN-bit input vector onto a
//   combinational function block and compares its N_FN reference outputs
//   with the N_FN reduced outputs. It counts the vectors that mismatch and
//   records the first failing vector and its difference mask.
//
//   Each vector takes two cycles. DRIVE holds vec_out for one settle cycle,
//   and SAMPLE then compares and advances to the next vector.
//
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   start           in   starts a sweep when sampled high in IDLE
//   vec_out         out  registered vector driven to the function block
//   fn_ref          in   unreduced function outputs (bit 0 = f)
//   fn_red          in   reduced function outputs (same bit order)
//   busy            out  high in DRIVE and SAMPLE
//   done            out  one-cycle pulse in DONE
//   pass            out  last completed sweep had no mismatches
//   err_count       out  number of mismatching vectors (0..2^N_IN)
//   first_fail_vec  out  vector of the first mismatch, 0 if none
//   first_fail_mask out  fn_ref^fn_red at the first mismatch, 0 if none
//
// Build option
//   SWEEP_STOP_ON_FAIL_EN : if defined, the sweep ends at the first
//   mismatching vector. vec_out stays frozen on that vector.
module equiv_sweep_ctrl #(
   parameter int N_IN = 5,
   parameter int N_FN = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] vec_out,
   input  logic [N_FN-1:0] fn_ref,
   input  logic [N_FN-1:0] fn_red,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail_vec,
   output logic [N_FN-1:0] first_fail_mask
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DRIVE  = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [N_IN:0] ERR_ONE = {{N_IN{1'b0}}, 1'b1};

   logic [1:0]      state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [N_IN:0]   err_q, err_d;
   logic [N_IN-1:0] ffv_q, ffv_d;
   logic [N_FN-1:0] ffm_q, ffm_d;
   logic            pass_q, pass_d;

   logic [N_FN-1:0] diff;
   logic            mismatch;
   logic            vec_last;

   // X on the inputs is not filtered. An X diff does not count as a mismatch.
   assign diff     = fn_ref ^ fn_red;
   assign mismatch = |diff;
   assign vec_last = &vec_q;

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      err_d   = err_q;
      ffv_d   = ffv_q;
      ffm_d   = ffm_q;
      pass_d  = pass_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_DRIVE;
               vec_d   = '0;
               err_d   = '0;
               ffv_d   = '0;
               ffm_d   = '0;
               pass_d  = 1'b0;
            end
         end
         S_DRIVE: begin
            state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (mismatch) begin
               err_d = err_q + ERR_ONE;
               // A count of zero means this is the first mismatch of the sweep.
               if (err_q == '0) begin
                  ffv_d = vec_q;
                  ffm_d = diff;
               end
            end
`ifdef SWEEP_STOP_ON_FAIL_EN
            if (mismatch) begin
               state_d = S_DONE;
               pass_d  = 1'b0;
            end else if (vec_last) begin
               state_d = S_DONE;
               pass_d  = (err_d == '0);
            end else begin
               vec_d   = vec_q + 1'b1;
               state_d = S_DRIVE;
            end
`else
            // On the last vector, vec_out stays at all ones instead of wrapping.
            if (vec_last) begin
               state_d = S_DONE;
               pass_d  = (err_d == '0);
            end else begin
               vec_d   = vec_q + 1'b1;
               state_d = S_DRIVE;
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         err_q   <= '0;
         ffv_q   <= '0;
         ffm_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffm_q   <= ffm_d;
         pass_q  <= pass_d;
      end
   end

   assign vec_out         = vec_q;
   assign busy            = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
   assign done            = (state_q == S_DONE);
   assign pass            = pass_q;
   assign err_count       = err_q;
   assign first_fail_vec  = ffv_q;
   assign first_fail_mask = ffm_q;

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Testbench for equiv_sweep_ctrl.
//   A behavioural function block drives fn_ref from vec_out. fn_red is
//   fn_ref XOR a per-mode flip pattern. Each sweep pushes its expected
//   results to a scoreboard queue, and the entry is popped when done pulses.
//   Honours SWEEP_STOP_ON_FAIL_EN when the same define is applied to the bench.
module tb_equiv_sweep_ctrl;

   localparam int N_IN = 5;
   localparam int N_FN = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            start = 1'b0;
   logic [N_IN-1:0] vec_out;
   logic [N_FN-1:0] fn_ref, fn_red;
   logic            busy, done, pass;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] first_fail_vec;
   logic [N_FN-1:0] first_fail_mask;

   int mode_r = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [N_IN:0]   err;
      logic [N_IN-1:0] ffv;
      logic [N_FN-1:0] ffm;
      logic            pass;
      int              done_c;
      int              last_vec;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   equiv_sweep_ctrl #(.N_IN(N_IN), .N_FN(N_FN)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .vec_out         (vec_out),
      .fn_ref          (fn_ref),
      .fn_red          (fn_red),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .err_count       (err_count),
      .first_fail_vec  (first_fail_vec),
      .first_fail_mask (first_fail_mask)
   );

   function automatic logic [N_FN-1:0] ref_fn(input logic [N_IN-1:0] v);
      return {v[4] ^ v[2], v[3] & v[0], v[1] | v[4], ^v};
   endfunction

   function automatic logic [N_FN-1:0] flip_fn(input int mode, input logic [N_IN-1:0] v);
      logic [N_FN-1:0] f;
      f = '0;
      case (mode)
         1: if (v == 5'd10) f = 4'b0100;
         2: begin
            if (v == 5'd3)  f = 4'b0001;
            if (v == 5'd20) f = 4'b1111;
         end
         3: f = 4'b1111;
         default: f = '0;
      endcase
      return f;
   endfunction

   // Behavioural stand-in for the function block under test.
   always_comb begin
      fn_ref = ref_fn(vec_out);
      fn_red = fn_ref ^ flip_fn(mode_r, vec_out);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vec"},  32'(vec_out), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_pass"}, 32'(pass), 0);
      chk({tag, "_err"},  32'(err_count), 0);
      chk({tag, "_ffv"},  32'(first_fail_vec), 0);
      chk({tag, "_ffm"},  32'(first_fail_mask), 0);
   endtask

   // Reference model for one sweep.
   function automatic exp_t model(input int mode);
      exp_t e;
      logic [N_FN-1:0] d;
      e.err = '0; e.ffv = '0; e.ffm = '0;
      e.done_c = 2 * (1 << N_IN);
      e.last_vec = (1 << N_IN) - 1;
      for (int v = 0; v < (1 << N_IN); v++) begin
         d = flip_fn(mode, v[N_IN-1:0]);
         if (d != '0) begin
            if (e.err == '0) begin
               e.ffv = v[N_IN-1:0];
               e.ffm = d;
            end
            e.err = e.err + 1'b1;
`ifdef SWEEP_STOP_ON_FAIL_EN
            e.last_vec = v;
            e.done_c = 2 * v + 2;
            break;
`endif
         end
      end
      e.pass = (e.err == '0);
      return e;
   endfunction

   task automatic sweep(input int mode, input bit disturb);
      exp_t e, got_e;
      bit got;
      int ev;
      e = model(mode);
      sb.push_back(e);
      mode_r = mode;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);   // edge k
      #1 start = 1'b0;
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk); // just after edge k+c
         if (disturb && c == 19) start = 1'b1;  // sampled at edge k+20
         if (disturb && c == 20) start = 1'b0;
         ev = (c / 2 > e.last_vec) ? e.last_vec : c / 2;
         chk("vec_out_walk", 32'(vec_out), 32'(ev));
         chk("busy", 32'(busy), (c < e.done_c) ? 1 : 0);
         if (done) begin
            got = 1;
            got_e = sb.pop_front();
            chk("done_cycle", 32'(c), 32'(got_e.done_c));
            chk("err_count", 32'(err_count), 32'(got_e.err));
            chk("first_fail_vec", 32'(first_fail_vec), 32'(got_e.ffv));
            chk("first_fail_mask", 32'(first_fail_mask), 32'(got_e.ffm));
            chk("pass", 32'(pass), 32'(got_e.pass));
         end
      end
      if (!got) chk("done_timeout", 0, 1);
      @(negedge clk);
      chk("idle_done", 32'(done), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("hold_err", 32'(err_count), 32'(e.err));
      chk("hold_pass", 32'(pass), 32'(e.pass));
      chk("hold_vec", 32'(vec_out), 32'(e.last_vec));
      $display("sweep mode=%0d disturb=%0d err_count=%0d ffv=%0d ffm=%b pass=%0d",
               mode, disturb, err_count, first_fail_vec, first_fail_mask, pass);
   endtask

   initial begin
      // Power-on reset: outputs must clear asynchronously.
      #3 rst_n = 1'b0;
      #1 chk_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      sweep(0, 1'b0);   // fn_red == fn_ref
      sweep(1, 1'b0);   // bit 2 flipped at vec 10
      sweep(2, 1'b0);   // bit 0 at vec 3, bits 3:0 at vec 20
      sweep(3, 1'b0);   // every output inverted at every vector
      sweep(0, 1'b1);   // start re-pulsed mid-sweep

      // Reset in the middle of a sweep.
      mode_r = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 0; c < 29; c++) @(posedge clk);
      #1 chk("pre_reset_vec", 32'(vec_out), 14);
      chk("pre_reset_busy", 32'(busy), 1);
      @(posedge clk);   // edge k+30
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midreset");
      @(negedge clk);
      chk_all_zero("midreset_held");
      rst_n = 1'b1;
      $display("reset asserted mid-sweep, outputs cleared");

      sweep(1, 1'b0);   // restart after reset begins at vec 0

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
